// File: rtl/tt_signature_sweeper.sv
// Truth-table sweeper: drives every input vector into a combinational circuit,
// streams each sampled row on a valid/ready port and accumulates per-output ones-counts.
module tt_signature_sweeper #(
  parameter int N_IN   = 5,
  parameter int N_OUT  = 4,
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic [N_IN-1:0]             dut_in,
  input  logic [N_OUT-1:0]            dut_out,
  output logic                        tt_valid,
  input  logic                        tt_ready,
  output logic [N_IN-1:0]             tt_idx,
  output logic [N_OUT-1:0]            tt_bits,
  output logic                        sig_valid,
  output logic [N_OUT*(N_IN+1)-1:0]   sig_count
);

  localparam int CW = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_EMIT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N_IN-1:0] r_vec;
  logic [3:0]      r_settle;
  logic            w_hs;
  logic            w_last;
  logic            w_sample;

  assign w_hs     = tt_valid && tt_ready;
  assign w_last   = (r_vec == LAST_VEC);
  assign w_sample = (r_state == S_DRIVE) && (r_settle == 4'd1);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_DRIVE;
      S_DRIVE: begin
        if (abort)         w_next = S_IDLE;
        else if (w_sample) w_next = S_EMIT;
      end
      S_EMIT: begin
        if (abort)     w_next = S_IDLE;
        else if (w_hs) w_next = w_last ? S_IDLE : S_DRIVE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      dut_in    <= '0;
      tt_valid  <= 1'b0;
      tt_idx    <= '0;
      tt_bits   <= '0;
      sig_valid <= 1'b0;
      sig_count <= '0;
      r_vec     <= '0;
      r_settle  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            r_vec     <= '0;
            dut_in    <= '0;
            r_settle  <= SETTLE_LD;
            sig_count <= '0;
            sig_valid <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            busy   <= 1'b0;
            dut_in <= '0;
          end else begin
            r_settle <= r_settle - 4'd1;
            if (w_sample) begin
              tt_bits  <= dut_out;
              tt_idx   <= r_vec;
              tt_valid <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          // Abort wins over a same-cycle handshake: the row is dropped uncounted.
          if (abort) begin
            tt_valid <= 1'b0;
            busy     <= 1'b0;
            dut_in   <= '0;
          end else if (w_hs) begin
            tt_valid <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
              sig_count[k*CW +: CW] <= sig_count[k*CW +: CW] + {{(CW-1){1'b0}}, tt_bits[k]};
            end
            if (w_last) begin
              done      <= 1'b1;
              sig_valid <= 1'b1;
              busy      <= 1'b0;
              dut_in    <= '0;
            end else begin
              r_vec    <= r_vec + 1'b1;
              dut_in   <= r_vec + 1'b1;
              r_settle <= SETTLE_LD;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_signature_sweeper.sv
// Scoreboard bench for tt_signature_sweeper: expected rows are queued at stimulus time
// and popped by independent monitors on each handshake.
module tb_tt_signature_sweeper;

  localparam int N_IN  = 5;
  localparam int N_OUT = 4;
  localparam int SW    = N_OUT * (N_IN + 1);

  typedef struct packed {
    logic [N_IN-1:0]  idx;
    logic [N_OUT-1:0] bits;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, tt_ready, start_b;
  logic busy_a, done_a, tt_valid_a, sig_valid_a;
  logic [N_IN-1:0] dut_in_a, tt_idx_a;
  logic [N_OUT-1:0] dut_out_a, tt_bits_a;
  logic [SW-1:0] sig_count_a;
  logic busy_b, done_b, tt_valid_b, sig_valid_b;
  logic [N_IN-1:0] dut_in_b, tt_idx_b;
  logic [N_OUT-1:0] dut_out_b, tt_bits_b;
  logic [SW-1:0] sig_count_b;

  logic [1:0] mode;          // 0 identity, 1 partial product, 2 identity delayed 2 cycles
  bit rdy_rand, expect_mm;
  int checks, failures, mm_cnt, done_pulses;
  row_t qa[$], qb[$];
  logic [N_IN-1:0] d1a = '0, d2a = '0, d1b = '0, d2b = '0;

  tt_signature_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy_a), .done(done_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .tt_valid(tt_valid_a), .tt_ready(tt_ready),
    .tt_idx(tt_idx_a), .tt_bits(tt_bits_a), .sig_valid(sig_valid_a), .sig_count(sig_count_a)
  );

  tt_signature_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .busy(busy_b), .done(done_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .tt_valid(tt_valid_b), .tt_ready(1'b1),
    .tt_idx(tt_idx_b), .tt_bits(tt_bits_b), .sig_valid(sig_valid_b), .sig_count(sig_count_b)
  );

  // Circuits under match.
  always_comb begin
    logic [3:0] p;
    p = {2'b00, dut_in_a[1:0]} * {2'b00, dut_in_a[3], dut_in_a[2]};
    case (mode)
      2'd1:    dut_out_a = {2'b00, p[1:0]};
      2'd2:    dut_out_a = d2a[3:0];
      default: dut_out_a = dut_in_a[3:0];
    endcase
  end
  assign dut_out_b = d2b[3:0];

  initial forever begin
    @(posedge clk);
    d1a <= dut_in_a; d2a <= d1a;
    d1b <= dut_in_b; d2b <= d1b;
  end

  // Reference: a = {a1,a0}, b = {b1,b0}; outputs are the low two product bits.
  function automatic logic [N_OUT-1:0] model(logic [1:0] m, int i);
    logic [N_IN-1:0] v;
    int a, b, p;
    v = N_IN'(i);
    a = int'(v[1:0]);
    b = 2 * int'(v[3]) + int'(v[2]);
    p = (a * b) % 4;
    if (m == 2'd1) return N_OUT'(p);
    return v[3:0];
  endfunction

  function automatic logic [SW-1:0] exp_sig(logic [1:0] m, int n);
    int c[N_OUT];
    logic [N_OUT-1:0] b;
    logic [SW-1:0] r;
    foreach (c[k]) c[k] = 0;
    for (int i = 0; i < n; i++) begin
      b = model(m, i);
      for (int k = 0; k < N_OUT; k++) c[k] += int'(b[k]);
    end
    r = '0;
    for (int k = 0; k < N_OUT; k++) r[k*(N_IN+1) +: (N_IN+1)] = (N_IN+1)'(c[k]);
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Ready driver: random backpressure when enabled, otherwise held high.
  initial forever begin
    @(posedge clk); #1;
    tt_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (done_a) done_pulses++;
  end

  // Monitor A: pop on handshake, check hold-while-stalled.
  initial begin : mon_a
    bit pend;
    row_t held, got, e;
    pend = 0;
    held = '0;
    forever begin
      @(negedge clk);
      got = row_t'{tt_idx_a, tt_bits_a};
      if (pend && tt_valid_a) check("row_hold_stable", 32'(got), 32'(held));
      if (rst_n && tt_valid_a && tt_ready && !abort) begin
        if (qa.size() == 0) check("row_unexpected_a", 32'(got), 32'h1ff);
        else begin
          e = qa.pop_front();
          if (expect_mm) begin
            if (got !== e) mm_cnt++;
          end else check("row_a", 32'(got), 32'(e));
        end
      end
      pend = rst_n && tt_valid_a && !tt_ready && !abort;
      held = got;
    end
  end

  initial begin : mon_b
    row_t e;
    forever begin
      @(negedge clk);
      if (rst_n && tt_valid_b) begin
        if (qb.size() == 0) check("row_unexpected_b", 32'({tt_idx_b, tt_bits_b}), 32'h1ff);
        else begin
          e = qb.pop_front();
          check("row_b_settle3", 32'({tt_idx_b, tt_bits_b}), 32'(e));
        end
      end
    end
  end

  task automatic push_rows(logic [1:0] m, int n);
    for (int i = 0; i < n; i++) qa.push_back(row_t'{N_IN'(i), model(m, i)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_row(int idx);
    int k;
    k = 0;
    while (!(tt_valid_a && tt_idx_a == N_IN'(idx)) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check("reach_row", 32'(tt_idx_a), 32'(idx));
  endtask

  task automatic run_full(logic [1:0] m, bit rnd, bit chk_lat);
    int n;
    mode = m;
    rdy_rand = rnd;
    push_rows(m, 1 << N_IN);
    pulse_start();
    @(negedge clk);
    check("busy_after_start", 32'(busy_a), 32'd1);
    check("dut_in_first", 32'(dut_in_a), 32'd0);
    n = 0;
    while (!done_a && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_a), 32'd1);
    if (chk_lat) check("done_latency", 32'(n), 32'd64);
    check("busy_at_done", 32'(busy_a), 32'd0);
    check("sig_valid_at_done", 32'(sig_valid_a), 32'd1);
    if (!expect_mm) check("sig_count", 32'(sig_count_a), 32'(exp_sig(m, 1 << N_IN)));
    check("queue_drained", 32'(qa.size()), 32'd0);
    rdy_rand = 0;
  endtask

  task automatic check_reset_vals();
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_dut_in", 32'(dut_in_a), 0);
    check("rst_tt_valid", 32'(tt_valid_a), 0);
    check("rst_tt_idx", 32'(tt_idx_a), 0);
    check("rst_tt_bits", 32'(tt_bits_a), 0);
    check("rst_sig_valid", 32'(sig_valid_a), 0);
    check("rst_sig_count", 32'(sig_count_a), 0);
  endtask

  initial begin
    int n, dp;
    rst_n = 0; start = 0; abort = 0; start_b = 0; tt_ready = 1;
    mode = 0; rdy_rand = 0; expect_mm = 0;
    checks = 0; failures = 0; mm_cnt = 0; done_pulses = 0;
    #12;
    check_reset_vals();
    @(posedge clk); #1 rst_n = 1;

    // Identity loopback with latency check.
    run_full(2'd0, 0, 1);

    // Partial product; signature must hold until next start.
    run_full(2'd1, 0, 0);
    repeat (5) @(negedge clk);
    check("sig_valid_held", 32'(sig_valid_a), 32'd1);
    check("sig_count_held", 32'(sig_count_a), 32'(exp_sig(2'd1, 32)));

    // Random backpressure.
    run_full(2'd0, 1, 0);

    // Slow circuit sampled too early must mismatch.
    expect_mm = 1;
    mm_cnt = 0;
    run_full(2'd2, 0, 0);
    expect_mm = 0;
    check("settle1_mismatch_seen", 32'(mm_cnt > 0), 32'd1);

    // Same slow circuit with SETTLE=3.
    for (int i = 0; i < 32; i++) qb.push_back(row_t'{N_IN'(i), model(2'd0, i)});
    @(posedge clk); #1 start_b = 1;
    @(posedge clk); #1 start_b = 0;
    @(negedge clk);
    n = 0;
    while (!done_b && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("s3_done_latency", 32'(n), 32'd128);
    check("s3_sig_valid", 32'(sig_valid_b), 32'd1);
    check("s3_sig_count", 32'(sig_count_b), 32'(exp_sig(2'd0, 32)));
    check("s3_queue_drained", 32'(qb.size()), 32'd0);

    // Abort during row 10 EMIT with ready high.
    mode = 0;
    push_rows(2'd0, 10);
    pulse_start();
    wait_row(10);
    dp = done_pulses;
    abort = 1;
    @(posedge clk); #1 abort = 0;
    check("abort_busy", 32'(busy_a), 0);
    check("abort_tt_valid", 32'(tt_valid_a), 0);
    check("abort_sig_valid", 32'(sig_valid_a), 0);
    check("abort_partial_count", 32'(sig_count_a), 32'(exp_sig(2'd0, 10)));
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(done_pulses), 32'(dp));
    check("abort_queue_drained", 32'(qa.size()), 0);
    run_full(2'd0, 0, 1);

    // Start while busy ignored, then reset mid-sweep at row 20.
    push_rows(2'd0, 20);
    pulse_start();
    wait_row(5);
    start = 1;
    repeat (2) @(posedge clk);
    #1 start = 0;
    wait_row(20);
    dp = done_pulses;
    rst_n = 0;
    #1;
    check_reset_vals();
    check("reset_queue_drained", 32'(qa.size()), 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (10) @(negedge clk);
    check("post_reset_idle_valid", 32'(tt_valid_a), 0);
    check("post_reset_idle_busy", 32'(busy_a), 0);
    check("post_reset_no_done", 32'(done_pulses), 32'(dp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
